// File: rtl/rom_pkg.sv
// Shared definitions for the ROM fetch sequencer and the ROM instance it reads.
package rom_pkg;

    localparam int ROM_AW = 12;
    localparam int ROM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/rom_fetch_seq_if.sv
// ROM read port plus the valid/ready output stream of the fetch sequencer.
interface rom_fetch_seq_if
    import rom_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
);

    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    // Sequencer side: drives the ROM address and the stream, reads ROM data and consumer ready.
    modport master (
        output rom_addr,
        input  rom_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    // ROM/consumer side.
    modport slave (
        input  rom_addr,
        output rom_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry synchronous FIFO; push and pop in the same cycle leave the count unchanged.
module skid_fifo2
    import rom_pkg::*;
#(
    parameter int DW = ROM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;

    // Next-state: write at the tail on push, advance the head on pop.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Storage and pointers; cleared storage keeps dout at zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rom_fetch_seq.sv
// Burst reader for a registered-read ROM: issues sequential addresses and
// re-times the one-cycle read latency onto a full-throughput valid/ready stream.
module rom_fetch_seq
    import rom_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   len,
    input  logic            loop,
    rom_fetch_seq_if.master bus,
    output logic            busy,
    output logic            done
);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] len_q, len_d;
    logic          loop_q, loop_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;

    logic [1:0]    fifo_count;
    logic [DW-1:0] fifo_dout;
    logic          pop;
    logic          flush;
    logic          fifo_rst_n;
    logic [2:0]    occ;
    logic [2:0]    occ_after;
    logic          issue;

    assign pop        = bus.out_valid && bus.out_ready;
    assign flush      = abort && (state_q != ST_IDLE);
    // Abort empties the buffer through its synchronous clear.
    assign fifo_rst_n = rst_n && !flush;

    // Buffered words plus the word the ROM is returning right now.
    assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign occ_after = occ - {2'b00, pop};
    // Only issue when the returning word is guaranteed a free slot.
    assign issue     = (state_q == ST_RUN) && (remaining_q != '0) && ((occ < 3'd2) || pop);

    // Sequencer next-state, address counter and done pulse.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        base_d      = base_q;
        len_d       = len_q;
        loop_d      = loop_q;
        inflight_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = ST_RUN;
                        ptr_d       = base_addr;
                        remaining_d = len;
                        base_d      = base_addr;
                        len_d       = len;
                        loop_d      = loop;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                end else if (issue) begin
                    inflight_d = 1'b1;
                    if (remaining_q == AW'(1)) begin
                        if (loop_q) begin
                            // Reload in the same edge so the repeat has no bubble.
                            ptr_d       = base_q;
                            remaining_d = len_q;
                        end else begin
                            ptr_d       = ptr_q + AW'(1);
                            remaining_d = '0;
                            state_d     = ST_DRAIN;
                        end
                    end else begin
                        ptr_d       = ptr_q + AW'(1);
                        remaining_d = remaining_q - AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (occ_after == 3'd0) begin
                    // Last word leaves at this edge: finish and pulse done.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            base_q      <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            base_q      <= base_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

    skid_fifo2 #(.DW(DW)) u_fifo (
        .clk   (clk),
        .rst_n (fifo_rst_n),
        .push  (inflight_q),
        .pop   (pop),
        .din   (bus.rom_data),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign bus.rom_addr  = ptr_q;
    assign bus.out_data  = fifo_dout;
    assign bus.out_valid = (fifo_count != 2'd0);
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Scoreboard bench for rom_fetch_seq with a registered-read ROM model (rom[i] = i[7:0]).
module tb_rom_fetch_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic [11:0] len;
    logic        loop;
    logic        busy;
    logic        done;

    rom_fetch_seq_if #(.AW(12), .DW(8)) bus ();

    rom_fetch_seq #(.AW(12), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .loop      (loop),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    logic [7:0] rom [4096];
    logic [7:0] exp_q [$];
    int         xfer_cyc_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         xfer_total = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         busy_seen = 0;
    int         valid_seen = 0;
    int         fifo_max = 0;
    logic       stall_prev = 1'b0;
    logic       abort_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read ROM model.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every transfer against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (stall_prev && !abort_prev) begin
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_data", int'(bus.out_data), int'(data_prev));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", int'(bus.out_data), -1);
            end else begin
                check("word", int'(bus.out_data), int'(exp_q.pop_front()));
            end
            xfer_total++;
            xfer_cyc_q.push_back(cyc);
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        data_prev  = bus.out_data;
        abort_prev = abort || !rst_n;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_seen = 1;
        if (bus.out_valid) valid_seen = 1;
        if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] b, input logic [11:0] l, input logic lp);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        loop      = lp;
        tick();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic push_burst(input logic [11:0] b, input int n);
        logic [11:0] a;
        a = b;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a[7:0]);
            a = a + 12'd1;
        end
    endtask

    task automatic wait_idle(input string nm, input int max_cyc);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        if (n >= max_cyc) check({nm, "_timeout"}, n, 0);
        tick();
    endtask

    initial begin
        int d0;
        int x0;
        int n;
        logic [11:0] a;
        logic pat [6];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            a = 12'(i);
            rom[i] = a[7:0];
        end
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; len = '0; loop = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_data", int'(bus.out_data), 0);
        check("rst_addr", int'(bus.rom_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // 1: basic burst, full throughput
        xfer_cyc_q.delete();
        d0 = done_cnt;
        push_burst(12'h010, 4);
        do_start(12'h010, 12'd4, 1'b0);
        wait_idle("t1", 30);
        check("t1_nwords", xfer_cyc_q.size(), 4);
        if (xfer_cyc_q.size() == 4) begin
            check("t1_first_cyc", xfer_cyc_q[0] - start_cyc, 2);
            check("t1_last_cyc", xfer_cyc_q[3] - start_cyc, 5);
        end
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_done_cyc", done_cyc - start_cyc, 6);
        check("t1_busy", int'(busy), 0);

        // 2: same burst with backpressure pattern
        x0 = xfer_total;
        d0 = done_cnt;
        push_burst(12'h010, 4);
        do_start(12'h010, 12'd4, 1'b0);
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 60) begin
            bus.out_ready = pat[n % 6];
            tick();
            n++;
        end
        if (n >= 60) check("t2_timeout", n, 0);
        bus.out_ready = 1'b1;
        tick();
        check("t2_nwords", xfer_total - x0, 4);
        check("t2_done_cnt", done_cnt - d0, 1);

        // 3: address wrap across 2**AW
        x0 = xfer_total;
        push_burst(12'hFFE, 4);
        do_start(12'hFFE, 12'd4, 1'b0);
        wait_idle("t3", 30);
        check("t3_nwords", xfer_total - x0, 4);

        // 4: looping burst, abort after the 7th word
        xfer_cyc_q.delete();
        x0 = xfer_total;
        d0 = done_cnt;
        for (int r = 0; r < 4; r++) push_burst(12'h020, 3);
        do_start(12'h020, 12'd3, 1'b1);
        n = 0;
        while (xfer_total - x0 < 7 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("t4_timeout", n, 0);
        abort = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        abort = 1'b0;
        check("t4_valid_after_abort", int'(bus.out_valid), 0);
        check("t4_busy_after_abort", int'(busy), 0);
        if (xfer_cyc_q.size() >= 7) check("t4_no_bubble", xfer_cyc_q[6] - xfer_cyc_q[0], 6);
        exp_q.delete();
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_valid_idle", int'(bus.out_valid), 0);

        // 5: zero-length start
        d0 = done_cnt;
        busy_seen = 0;
        valid_seen = 0;
        do_start(12'h123, 12'd0, 1'b0);
        repeat (3) tick();
        check("t5_done_cnt", done_cnt - d0, 1);
        check("t5_busy_seen", busy_seen, 0);
        check("t5_valid_seen", valid_seen, 0);

        // 6: reset mid-burst, then a one-word burst
        bus.out_ready = 1'b0;
        do_start(12'h040, 12'd8, 1'b0);
        repeat (5) tick();
        check("t6_buffered", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", int'(bus.out_valid), 0);
        check("t6_rst_data", int'(bus.out_data), 0);
        check("t6_rst_addr", int'(bus.rom_addr), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_done", int'(done), 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        x0 = xfer_total;
        d0 = done_cnt;
        push_burst(12'h005, 1);
        do_start(12'h005, 12'd1, 1'b0);
        wait_idle("t6", 30);
        repeat (2) tick();
        check("t6_nwords", xfer_total - x0, 1);
        check("t6_done_cnt", done_cnt - d0, 1);

        check("fifo_max_le2", int'(fifo_max <= 2), 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_fetch_seq.md
Name: rom_fetch_seq

Overview:
- Initiator/reader for the team's synchronous ROM.
  - The ROM is registered-read: an address sampled at one clk edge produces data in the following cycle.
- The block generates a burst of sequential ROM addresses from a base and a length.
- It absorbs the 1-cycle read latency and delivers the words on a valid/ready stream with full throughput and backpressure.
- It sits between the ROM and any consumer (display driver, pattern generator, serializer).

Parameters:
- AW, 12, ROM address width; addresses wrap modulo 2**AW.
- DW, 8, ROM data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous, active-low).
- start  in  1  begin burst; sampled only in IDLE.
- abort  in  1  cancel burst; sampled in RUN/DRAIN.
- base_addr  in  AW  first address; latched on accepted start.
- len  in  AW  word count; latched on accepted start.
- loop  in  1  repeat burst indefinitely; latched on accepted start.
- rom_addr  out  AW  registered address to ROM.
- rom_data  in  DW  ROM read data, valid the cycle after rom_addr is sampled.
- out_data  out  DW  stream data (head of buffer).
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready; a transfer occurs when out_valid && out_ready.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when a non-loop burst has fully drained, or when a len==0 start is accepted.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; rom_addr=0; out_valid=0; out_data=0; busy=0; done=0.
  - Buffer count=0; inflight=0; remaining=0.
  - Reset overrides all other inputs.
- States:
  - IDLE:
    - start=1 and len!=0 → RUN; ptr=base_addr; remaining=len; loop latched.
    - start=1 and len==0 → stay IDLE; done=1 for one cycle.
  - RUN:
    - Issue: rom_addr=ptr is valid during the cycle. An issue occurs at an edge when remaining>0 and (count+inflight<2 or pop).
    - On issue: ptr+=1 mod 2**AW; remaining-=1; inflight=1 next cycle, otherwise inflight=0.
    - When remaining hits 0 and loop=1: ptr=base, remaining=len in the same edge, with no bubble.
    - When remaining hits 0 and loop=0: → DRAIN.
  - DRAIN:
    - No issues.
    - When count==0, inflight==0 and no pending push → IDLE with a done pulse.
    - done asserts the cycle after the last word transfers.
- Capture:
  - When inflight=1, rom_data is pushed into a 2-entry FIFO at the edge.
  - Push and pop in the same edge are legal; count is unchanged.
  - The FIFO never overflows: the issue rule guarantees count+inflight≤2 after every edge.
- Output:
  - out_valid = count>0; out_data = FIFO head.
  - Data stays stable while out_valid && !out_ready.
- Latency:
  - start accepted at edge E → first issue at E+1 → push at E+2 → out_valid high in the cycle after E+2.
  - With out_ready held high, one word transfers per cycle thereafter.
- abort=1 in RUN or DRAIN → IDLE at the next edge.
  - FIFO flushed; inflight discarded; out_valid=0; no done pulse.
- start while busy is ignored.
- A base+len crossing 2**AW wraps to address 0.
- rom_addr holds its last value in IDLE.

Decomposition:
- Shared package rom_pkg:
  - State encoding constants ST_IDLE, ST_RUN, ST_DRAIN.
  - Default AW/DW localparams shared with the ROM instance.
- One natural sub-module: skid_fifo2, a parameterised 2-entry synchronous FIFO.
  - Ports: push, pop, din, dout, count; synchronous active-low rst_n.
- The sequencer FSM and address counter stay in the top.

Test Plan:
1. ROM preloaded rom[i]=i[7:0]; base=0x010, len=4, loop=0, out_ready=1 → out_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles starting 2 cycles after the start edge; then a single done pulse, busy=0.
2. Same burst with out_ready toggled 1,0,0,1,0,1… → the same 4 words in order, none dropped or duplicated; out_data stable while stalled; FIFO count never exceeds 2.
3. base=0xFFE, len=4 → words from addresses 0xFFE,0xFFF,0x000,0x001.
4. base=0x020, len=3, loop=1, out_ready=1 → repeating 0x20,0x21,0x22,0x20… with no idle cycle; abort after the 7th word → out_valid=0 next cycle, state IDLE, no done pulse.
5. start with len=0 → done high exactly one cycle; busy never asserts; out_valid stays 0.
6. rst_n=0 mid-burst (2 words buffered) → next cycle all outputs at reset values; a following start with base=0x005, len=1 returns 0x05 only.
